input_debounce8: RTL
====================

Name: input_debounce8

Overview:
- Upstream conditioning stage for the 8-bit reduce-OR that drives the LED.
- Synchronises 8 raw header inputs (J1 pins) into the CLK domain and debounces each bit independently.
- Its output vector is the clean `I` bus consumed by the Or8 stage, plus a one-cycle change strobe.
- Target: icestick, 12 MHz CLK.

Parameters:
- WIDTH, 8, number of independent input bits.
- CNT_W, 16, per-bit stability counter width.
- DEBOUNCE_CYCLES, 12000, consecutive cycles a new level must persist before it is accepted (1 ms at 12 MHz). Legal range is 1 to 2^CNT_W-1. Elaboration fails outside this range.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RESETN  input  1  synchronous, active-low reset, sampled on rising CLK.
- I  input  WIDTH  raw asynchronous pin levels.
- O  output  WIDTH  debounced, registered levels; feeds the reduce-OR stage.
- CHANGED  output  1  one-cycle pulse: some bit of O changed on the previous edge.

Behaviour:
- Reset: on any rising edge with RESETN=0, the following are all cleared to 0 regardless of I:
  - sync regs s1 and s2
  - O
  - all counters cnt[i]
  - CHANGED
- Synchroniser: s1 <= I; s2 <= s1. Two flops per bit. No logic between s1 and s2.
- Per-bit counter, evaluated every edge with RESETN=1:
  - s2[i]==O[i]: cnt[i] <= 0; O[i] holds.
  - s2[i]!=O[i] and cnt[i]==DEBOUNCE_CYCLES-1: O[i] <= s2[i]; cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
- Latency: I held at a new level from sampling edge 0 → O[i] updates on edge DEBOUNCE_CYCLES+1. For DEBOUNCE_CYCLES=1, O updates on edge 2 (pure 2-flop sync plus 1 register).
- Glitch rejection:
  - Any return of s2[i] to O[i] before the count completes zeroes cnt[i].
  - The count restarts from 0 on the next mismatch. No partial credit is kept.
- Counter never wraps. The compare at DEBOUNCE_CYCLES-1 is the only exit path. cnt[i] never exceeds DEBOUNCE_CYCLES-1.
- Bits are fully independent:
  - Simultaneous transitions on several bits update together if their counts complete on the same edge.
  - CHANGED is still a single pulse in that case.
- CHANGED <= OR over i of (O[i] update on this edge):
  - High for exactly the cycle following each update edge.
  - Back-to-back updates on different bits in consecutive edges give CHANGED high on consecutive cycles.
- Reset mid-count: counters are discarded and O returns to 0.
  - After RESETN returns high, inputs already high need DEBOUNCE_CYCLES+1 edges from the first edge with RESETN=1.
  - Inputs held low produce no CHANGED pulse.
- No combinational path from I to O or CHANGED.

Optional Feature:
- Macro: INPUT_DEBOUNCE8_EDGE_FLAGS_EN.
- When defined, adds two outputs:
  - RISE (output, WIDTH): registered, reset 0, high for one cycle on the cycle after O[i] goes 0→1.
  - FALL (output, WIDTH): registered, reset 0, high for one cycle on the cycle after O[i] goes 1→0.
- RISE[i] and FALL[i] are never both high.
- When undefined:
  - RISE and FALL are absent from the port list.
  - No edge registers are synthesised.
  - All other behaviour is identical.

Test Plan:
- DEBOUNCE_CYCLES=4. Hold RESETN=0 for 3 edges with I=8'hFF, then release → O=8'h00 during reset. O becomes 8'hFF on the 5th edge after release. CHANGED pulses once.
- DEBOUNCE_CYCLES=4, O=8'h00. Pulse I[3]=1 for 3 cycles, then 0 → O stays 8'h00, CHANGED never asserts, cnt[3] returns to 0.
- DEBOUNCE_CYCLES=4, O=8'h00. Toggle I[0] high at edge 0 and I[7] high at edge 1, both held → O=8'h01 at edge 5, O=8'h81 at edge 6. CHANGED high in both following cycles.
- DEBOUNCE_CYCLES=4, O=8'h0F. Set I=8'hF0 at once and hold → O goes 8'h0F→8'hF0 on a single edge (5) with one CHANGED pulse. With INPUT_DEBOUNCE8_EDGE_FLAGS_EN: RISE=8'hF0 and FALL=8'h0F for that one cycle.
- DEBOUNCE_CYCLES=4. Assert RESETN=0 at edge 3 of a pending 0→1 count on I[2] (held high) → O=8'h00 immediately after. O[2]=1 only 5 edges after RESETN returns high.
- DEBOUNCE_CYCLES=1 → a sustained edge on I[5] reaches O[5] on edge 2. A 1-cycle pulse on I[5] also propagates (no filtering at the minimum setting).

Source files
------------

// File: rtl/input_debounce8.sv
// Two-flop synchroniser plus per-bit stability counter for the raw J1 header
// inputs. Define INPUT_DEBOUNCE8_EDGE_FLAGS_EN to add the RISE/FALL edge outputs.
module input_debounce8 #(
    parameter int WIDTH           = 8,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    output logic             CHANGED
`ifdef INPUT_DEBOUNCE8_EDGE_FLAGS_EN
    ,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL
`endif
);

    generate
        if (CNT_W < 1 || CNT_W > 32 || DEBOUNCE_CYCLES < 1 ||
            longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_cfg
            $error("input_debounce8: DEBOUNCE_CYCLES must lie in 1 .. 2**CNT_W-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] o_q;
    logic [WIDTH-1:0] o_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] upd;
    logic             changed_q;
    logic             changed_d;

    // A level is accepted only after LAST+1 consecutive mismatching samples;
    // any agreement with O in between throws the partial count away.
    always_comb begin
        o_d = o_q;
        upd = '0;
        for (int k = 0; k < WIDTH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (s2_q[k] == o_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == LAST) begin
                o_d[k]   = s2_q[k];
                cnt_d[k] = '0;
                upd[k]   = 1'b1;
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
        changed_d = |upd;
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            s1_q      <= '0;
            s2_q      <= '0;
            o_q       <= '0;
            changed_q <= 1'b0;
            for (int k = 0; k < WIDTH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            s1_q      <= I;
            s2_q      <= s1_q;
            o_q       <= o_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign O       = o_q;
    assign CHANGED = changed_q;

`ifdef INPUT_DEBOUNCE8_EDGE_FLAGS_EN
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;

    // An updated bit always flips, so its new value alone gives the direction.
    always_comb begin
        rise_d = upd & o_d;
        fall_d = upd & ~o_d;
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign RISE = rise_q;
    assign FALL = fall_q;
`endif

endmodule
